// File: rtl/ahb_slave_2_inport_mux.sv
// Master-to-slave path for slave_2: turns the arbiter grant into address/data-phase owners and muxes the owner onto slave_2.
// Latency: address/control are combinational from the grant; write data and response follow one cycle later (data phase).
// Backpressure: s_hreadyout low holds the data owner, raises hwait to the arbiter and drops m_hready to every master.
//
// Ports
//   hclk, hreset                      clock, synchronous active-high reset
//   hgrant, hsel_arb                  one-hot grant and select from the slave_2 arbiter
//   m_haddr .. m_hwdata               per-master address phase controls and write data
//   m_hready, m_hresp, m_hrdata       per-master ready/error and broadcast read data
//   s_hsel .. s_hwdata                muxed request towards slave_2
//   s_hrdata, s_hreadyout, s_hresp    slave_2 response
//   hburst, hwait                     burst type and wait indication back to the arbiter
//   grant_err                         sticky flag: a grant with more than one bit set was seen
module ahb_slave_2_inport_mux #(
  parameter int MASTER_NUM = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                  hclk,
  input  logic                                  hreset,
  input  logic [MASTER_NUM-1:0]                 hgrant,
  input  logic                                  hsel_arb,
  input  logic [MASTER_NUM-1:0][ADDR_WIDTH-1:0] m_haddr,
  input  logic [MASTER_NUM-1:0][1:0]            m_htrans,
  input  logic [MASTER_NUM-1:0]                 m_hwrite,
  input  logic [MASTER_NUM-1:0][2:0]            m_hsize,
  input  logic [MASTER_NUM-1:0][2:0]            m_hburst,
  input  logic [MASTER_NUM-1:0][DATA_WIDTH-1:0] m_hwdata,
  output logic [MASTER_NUM-1:0]                 m_hready,
  output logic [MASTER_NUM-1:0]                 m_hresp,
  output logic [DATA_WIDTH-1:0]                 m_hrdata,
  output logic                                  s_hsel,
  output logic [ADDR_WIDTH-1:0]                 s_haddr,
  output logic [1:0]                            s_htrans,
  output logic                                  s_hwrite,
  output logic [2:0]                            s_hsize,
  output logic [2:0]                            s_hburst,
  output logic [DATA_WIDTH-1:0]                 s_hwdata,
  input  logic [DATA_WIDTH-1:0]                 s_hrdata,
  input  logic                                  s_hreadyout,
  input  logic                                  s_hresp,
  output logic [2:0]                            hburst,
  output logic                                  hwait,
  output logic                                  grant_err
);

  // Registered owners (one-hot or zero) and the sticky grant error.
  logic [MASTER_NUM-1:0] a_own_q;
  logic [MASTER_NUM-1:0] d_own_q;
  logic                  grant_err_q;

  logic [MASTER_NUM-1:0] grant_low;   // lowest set bit of hgrant
  logic                  grant_multi; // more than one grant bit set
  logic [MASTER_NUM-1:0] a_eff;       // effective address-phase owner
  logic [MASTER_NUM-1:0] a_sel;       // a_eff qualified by hsel_arb: drives the address mux
  logic [MASTER_NUM-1:0] d_sel;       // data-phase owner, forced to zero while in reset

  // x & -x isolates the lowest set bit. For a legal one-hot grant this is
  // just hgrant, so the normal path stays a plain AND-OR mux; only an
  // illegal multi-bit grant is trimmed to its lowest index.
  assign grant_low   = hgrant & (~hgrant + MASTER_NUM'(1));
  assign grant_multi = |(hgrant & ~grant_low);

  // While the arbiter holds hgrant at zero during wait states, the owner
  // from the previous cycle keeps the address phase. Reset gates everything
  // combinationally so the outputs are idle in the reset cycle itself.
  always_comb begin
    a_eff = '0;
    if (!hreset) begin
      a_eff = (|hgrant) ? grant_low : a_own_q;
    end
  end

  assign a_sel = hsel_arb ? a_eff : '0;
  assign d_sel = hreset ? '0 : d_own_q;

  // AND-OR muxes over the one-hot selects; an all-zero select yields zero,
  // which is IDLE for htrans and SINGLE for hburst.
  always_comb begin
    s_haddr  = '0;
    s_htrans = '0;
    s_hwrite = 1'b0;
    s_hsize  = '0;
    s_hburst = '0;
    s_hwdata = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      s_haddr  = s_haddr  | (m_haddr[i]  & {ADDR_WIDTH{a_sel[i]}});
      s_htrans = s_htrans | (m_htrans[i] & {2{a_sel[i]}});
      s_hwrite = s_hwrite | (m_hwrite[i] & a_sel[i]);
      s_hsize  = s_hsize  | (m_hsize[i]  & {3{a_sel[i]}});
      s_hburst = s_hburst | (m_hburst[i] & {3{a_sel[i]}});
      s_hwdata = s_hwdata | (m_hwdata[i] & {DATA_WIDTH{d_sel[i]}});
    end
  end

  assign s_hsel = |a_sel;
  assign hburst = s_hburst;

  // Both the incoming address owner and the outgoing data owner see the
  // slave's ready, which lets a handover complete in a single cycle. Every
  // other master is stalled with hready low.
  assign m_hready  = {MASTER_NUM{s_hreadyout}} & (a_eff | d_sel);
  assign m_hresp   = {MASTER_NUM{s_hresp}} & d_sel;
  assign m_hrdata  = s_hrdata;
  assign hwait     = ~hreset & ~s_hreadyout;
  assign grant_err = grant_err_q & ~hreset;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      a_own_q     <= '0;
      d_own_q     <= '0;
      grant_err_q <= 1'b0;
    end else begin
      a_own_q <= a_sel;
      // The address phase only advances into the data phase when the slave
      // accepts it; during wait states the current data owner is kept.
      if (s_hreadyout) begin
        d_own_q <= a_sel;
      end
      if (grant_multi) begin
        grant_err_q <= 1'b1;
      end
    end
  end

endmodule
